// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the memory arbiter: word width, legal parameter
// bounds, derived counter widths and the access FSM state encoding.
package arbitro_memoria_pkg;

  localparam int unsigned WORD_W       = 32;

  localparam int unsigned MEM_LAT_MIN  = 1;
  localparam int unsigned MEM_LAT_MAX  = 7;
  localparam int unsigned FAIR_MAX_MIN = 1;
  localparam int unsigned FAIR_MAX_MAX = 15;

  // Counter widths sized to hold the largest legal parameter value.
  localparam int unsigned LAT_W  = $clog2(MEM_LAT_MAX + 1);
  localparam int unsigned FAIR_W = $clog2(FAIR_MAX_MAX + 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } estado_e;

endpackage

// File: rtl/arbitro_memoria_prioridade.sv
// arbitro_prioridade: grant decision plus fetch-starvation counter.
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   decide_i        - an arbitration slot is open this cycle
//   if_req_i        - fetch request pending
//   dm_req_i        - data (load/store) request pending
//   gnt_if_o        - fetch granted this cycle
//   gnt_dm_o        - data access granted this cycle
// Data normally wins; once FAIR_MAX data grants have been made while a fetch
// waited, the fetch is forced through and the counter clears.
module arbitro_prioridade
  import arbitro_memoria_pkg::*;
#(
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic decide_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic gnt_if_o,
  output logic gnt_dm_o
);

  localparam logic [FAIR_W-1:0] FAIR_LIM = FAIR_W'(FAIR_MAX);

  logic [FAIR_W-1:0] fair_q, fair_d;
  logic              fetch_forced;

  assign fetch_forced = if_req_i && (fair_q == FAIR_LIM);

  always_comb begin
    gnt_if_o = 1'b0;
    gnt_dm_o = 1'b0;
    fair_d   = fair_q;
    if (decide_i) begin
      if (if_req_i && (!dm_req_i || fetch_forced)) begin
        gnt_if_o = 1'b1;
        fair_d   = '0;
      end else if (dm_req_i) begin
        gnt_dm_o = 1'b1;
        // fetch_forced is false here, so fair_q < FAIR_LIM: no overflow.
        if (if_req_i) fair_d = fair_q + FAIR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fair_q <= '0;
    else          fair_q <= fair_d;
  end

endmodule

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: shares one memory port between instruction fetch and
// data (load/store) accesses, one access outstanding at a time.
// Ports:
//   clock, reset_n                   - clock, asynchronous active-low reset
//   if_req/if_addr -> if_rdata/if_valid  - fetch requester
//   dm_read/dm_write/dm_addr/dm_wdata -> dm_rdata/dm_valid/dm_err - data requester
//   mem_addr/mem_wdata/mem_ler/mem_esc <- mem_rdata - shared memory
//   stall_if, stall_pipe             - pipeline hold requests
// Each access lasts MEM_LAT+1 cycles: the latency counter loads MEM_LAT at
// grant, read data is captured as it steps to 0, and the cycle with the
// counter at 0 is the completion cycle (valid pulse, next grant decided).
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_ler,
  output logic              mem_esc,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_pipe
);

  localparam logic [LAT_W-1:0] LAT_INI = LAT_W'(MEM_LAT);

  estado_e           state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              wr_q, wr_d, first_q, first_d, err_q, err_d;
  logic              busy, done, capture, decide, dm_req, gnt_if, gnt_dm;

  assign busy    = (state_q != OCIOSO);
  assign done    = busy && (lat_q == '0);
  assign capture = busy && (lat_q == LAT_W'(1));
  assign decide  = !busy || done;
  assign dm_req  = dm_read | dm_write;

  arbitro_prioridade #(.FAIR_MAX(FAIR_MAX)) u_prio (
    .clock    (clock),
    .reset_n  (reset_n),
    .decide_i (decide),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .gnt_if_o (gnt_if),
    .gnt_dm_o (gnt_dm)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    first_d    = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    if (busy && lat_q != '0) lat_d = lat_q - LAT_W'(1);

    if (capture && state_q == BUSY_I)          if_rdata_d = mem_rdata;
    if (capture && state_q == BUSY_D && !wr_q) dm_rdata_d = mem_rdata;

    // A grant in the completion cycle overrides the return to OCIOSO.
    if (gnt_if) begin
      state_d = BUSY_I;
      lat_d   = LAT_INI;
      addr_d  = if_addr;
      wdata_d = '0;
      wr_d    = 1'b0;
      first_d = 1'b1;
    end else if (gnt_dm) begin
      state_d = BUSY_D;
      lat_d   = LAT_INI;
      addr_d  = dm_addr;
      wdata_d = dm_wdata;
      wr_d    = dm_write;
      first_d = 1'b1;
      err_d   = dm_read & dm_write;
    end else if (done) begin
      state_d = OCIOSO;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCIOSO;
      lat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      first_q    <= first_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign if_valid   = (state_q == BUSY_I) && (lat_q == '0);
  assign dm_valid   = (state_q == BUSY_D) && (lat_q == '0);
  assign dm_err     = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_ler    = (state_q == BUSY_I) || (state_q == BUSY_D && !wr_q);
  assign mem_esc    = (state_q == BUSY_D) && wr_q && first_q;
  assign stall_if   = if_req & ~if_valid;
  assign stall_pipe = dm_req & ~dm_valid;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a behavioural shared memory and a
// scoreboard of expected read data per requester. A second instance with
// MEM_LAT=3 is used for the mid-access reset scenario.
module tb_arbitro_memoria;

  logic        clock, reset_n;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, dm_err, mem_ler, mem_esc, stall_if, stall_pipe;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        if_valid3, dm_valid3, dm_err3, mem_ler3, mem_esc3, stall_if3, stall_pipe3;

  int checks = 0;
  int failures = 0;
  bit sb_en = 1'b0;
  logic [31:0] if_q [$];
  logic [31:0] dm_q [$];

  logic [31:0] mem [0:255];
  bit          written [0:255];

  arbitro_memoria #(.MEM_LAT(1), .FAIR_MAX(4)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ler(mem_ler), .mem_esc(mem_esc),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
  );

  arbitro_memoria #(.MEM_LAT(3), .FAIR_MAX(4)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata3), .dm_valid(dm_valid3), .dm_err(dm_err3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_ler(mem_ler3), .mem_esc(mem_esc3),
    .mem_rdata(mem_rdata3), .stall_if(stall_if3), .stall_pipe(stall_pipe3)
  );

  assign mem_rdata3 = 32'h5A5A_5A5A;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unwritten locations return a fixed pattern derived from the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    if (a == 32'h44) return 32'h2402_0005;
    if (a == 32'h48) return 32'hAAAA_0001;
    return 32'hD000_0000 | a;
  endfunction

  always @(posedge clock) begin
    if (mem_esc) begin
      mem[mem_addr[9:2]]     <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    if (written[mem_addr[9:2]]) mem_rdata = mem[mem_addr[9:2]];
    else                        mem_rdata = rom(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the expected read data whenever a valid pulse appears.
  always @(negedge clock) begin
    if (sb_en && if_valid) begin
      if (if_q.size() == 0) chk("sb_if_unexpected", {31'd0, if_valid}, 32'd0);
      else                  chk("sb_if_rdata", if_rdata, if_q.pop_front());
    end
    if (sb_en && dm_valid) begin
      if (dm_q.size() == 0) chk("sb_dm_unexpected", {31'd0, dm_valid}, 32'd0);
      else                  chk("sb_dm_rdata", dm_rdata, dm_q.pop_front());
    end
  end

  initial begin
    int    stall_cnt;
    int    nd;
    string order;
    logic [31:0] last_dm;

    reset_n = 1'b0; if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_valids", {28'd0, if_valid, dm_valid, dm_err, mem_esc}, 32'd0);
    chk("rst_ler_stall", {29'd0, mem_ler, stall_if, stall_pipe}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    reset_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clock);

    // Fetch alone
    if_addr = 32'h40; if_req = 1'b1; if_q.push_back(32'h8C01_0004);
    @(negedge clock);
    chk("s1_ler", {31'd0, mem_ler}, 32'd1);
    chk("s1_addr", mem_addr, 32'h40);
    chk("s1_valid_early", {31'd0, if_valid}, 32'd0);
    stall_cnt = int'(stall_if);
    @(negedge clock);
    chk("s1_if_valid", {31'd0, if_valid}, 32'd1);
    chk("s1_if_rdata", if_rdata, 32'h8C01_0004);
    stall_cnt += int'(stall_if);
    chk("s1_stall_cycles", 32'(stall_cnt), 32'd1);
    if_req = 1'b0;
    @(negedge clock);
    chk("s1_valid_pulse", {31'd0, if_valid}, 32'd0);
    chk("s1_idle_ler", {31'd0, mem_ler}, 32'd0);
    chk("s1_rdata_hold", if_rdata, 32'h8C01_0004);

    // Load and fetch in the same cycle: data first, fetch with no bubble
    dm_addr = 32'h100; dm_read = 1'b1; dm_q.push_back(rom(32'h100));
    if_addr = 32'h44;  if_req = 1'b1;  if_q.push_back(32'h2402_0005);
    @(negedge clock);
    chk("s2_first_addr", mem_addr, 32'h100);
    @(negedge clock);
    chk("s2_dm_valid", {30'd0, dm_valid, if_valid}, 32'b10);
    dm_read = 1'b0;
    @(negedge clock);
    chk("s2_no_bubble", {31'd0, mem_ler}, 32'd1);
    chk("s2_fetch_addr", mem_addr, 32'h44);
    @(negedge clock);
    chk("s2_if_valid", {31'd0, if_valid}, 32'd1);
    if_req = 1'b0;
    @(negedge clock);

    // Fairness: data held continuously while a fetch waits
    if_addr = 32'h48; if_req = 1'b1; if_q.push_back(32'hAAAA_0001);
    dm_addr = 32'h104; dm_read = 1'b1; dm_q.push_back(rom(32'h104));
    nd = 1; order = "";
    for (int cyc = 1; cyc <= 40 && order.len() < 6; cyc++) begin
      @(negedge clock);
      if (cyc == 7) chk("s3_fair_sat", 32'(u_dut.u_prio.fair_q), 32'd4);
      if (cyc == 9) chk("s3_fair_clr", 32'(u_dut.u_prio.fair_q), 32'd0);
      if (dm_valid) begin
        order = {order, "D"};
        if (nd < 5) begin
          dm_addr = 32'h104 + 32'(nd * 4);
          dm_q.push_back(rom(dm_addr));
          nd++;
        end else begin
          dm_read = 1'b0;
        end
      end
      if (if_valid) begin
        order = {order, "I"};
        if_req = 1'b0;
      end
    end
    checks++;
    assert (order == "DDDDID") else begin
      failures++;
      $error("FAIL s3_grant_order: observed=%s expected=DDDDID", order);
    end
    last_dm = rom(32'h114);
    @(negedge clock);

    // Store then load back
    dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_write = 1'b1; dm_q.push_back(last_dm);
    @(negedge clock);
    chk("s4_esc", {30'd0, mem_esc, mem_ler}, 32'b10);
    chk("s4_waddr", mem_addr, 32'h200);
    chk("s4_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s4_no_err", {31'd0, dm_err}, 32'd0);
    @(negedge clock);
    chk("s4_esc_one_cycle", {31'd0, mem_esc}, 32'd0);
    chk("s4_dm_valid", {31'd0, dm_valid}, 32'd1);
    dm_write = 1'b0;
    @(negedge clock);
    dm_read = 1'b1; dm_q.push_back(32'hDEAD_BEEF);
    @(negedge clock);
    @(negedge clock);
    chk("s4_load_valid", {31'd0, dm_valid}, 32'd1);
    chk("s4_load_data", dm_rdata, 32'hDEAD_BEEF);
    dm_read = 1'b0;
    last_dm = 32'hDEAD_BEEF;
    @(negedge clock);

    // Read and write together: performed as a store, dm_err pulses
    dm_addr = 32'h204; dm_wdata = 32'h0BAD_F00D; dm_read = 1'b1; dm_write = 1'b1;
    dm_q.push_back(last_dm);
    @(negedge clock);
    chk("s5_err", {29'd0, dm_err, mem_esc, mem_ler}, 32'b110);
    @(negedge clock);
    chk("s5_err_pulse", {30'd0, dm_err, dm_valid}, 32'b01);
    dm_read = 1'b0; dm_write = 1'b0;
    @(negedge clock);
    dm_read = 1'b1; dm_q.push_back(32'h0BAD_F00D);
    @(negedge clock);
    @(negedge clock);
    chk("s5_readback", dm_rdata, 32'h0BAD_F00D);
    dm_read = 1'b0;
    repeat (10) @(negedge clock);
    chk("sb_if_drained", 32'(if_q.size()), 32'd0);
    chk("sb_dm_drained", 32'(dm_q.size()), 32'd0);

    // Reset during BUSY_D on the MEM_LAT=3 instance
    sb_en = 1'b0;
    dm_addr = 32'h100; dm_read = 1'b1;
    @(negedge clock);
    chk("s6_busy", {31'd0, mem_ler3}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_flags", {27'd0, dm_valid3, dm_err3, mem_ler3, mem_esc3, if_valid3}, 32'd0);
    chk("s6_rst_addr", mem_addr3, 32'd0);
    chk("s6_rst_rdata", dm_rdata3 | if_rdata3 | mem_wdata3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("s6_no_valid", {31'd0, dm_valid3}, 32'd0);
    end
    reset_n = 1'b1;
    #1;
    chk("s6_no_early_grant", {31'd0, mem_ler3}, 32'd0);
    @(negedge clock);
    chk("s6_first_edge_grant", {31'd0, mem_ler3}, 32'd1);
    chk("s6_grant_addr", mem_addr3, 32'h100);
    @(negedge clock);
    @(negedge clock);
    chk("s6_not_yet", {31'd0, dm_valid3}, 32'd0);
    @(negedge clock);
    chk("s6_valid_lat3", {31'd0, dm_valid3}, 32'd1);
    chk("s6_rdata_lat3", dm_rdata3, 32'h5A5A_5A5A);
    dm_read = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameters SHALL be: MEM_LAT, default 1, cycles from grant to read data valid on mem_rdata (legal 1..7); FAIR_MAX, default 4, consecutive data grants allowed while a fetch waits (legal 1..15).
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request, held until if_valid.
- if_addr  in  32  fetch address (PC).
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle pulse: if_rdata valid, fetch done.
- dm_read  in  1  data load request, held until dm_valid.
- dm_write  in  1  data store request, held until dm_valid.
- dm_addr  in  32  data address (MEM-stage ALU result).
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data.
- dm_valid  out  1  one-cycle pulse: data access done.
- dm_err  out  1  one-cycle pulse: dm_read and dm_write both high at grant.
- mem_addr  out  32  address to shared memory.
- mem_wdata  out  32  write data to shared memory.
- mem_ler  out  1  memory read strobe.
- mem_esc  out  1  memory write strobe.
- mem_rdata  in  32  memory read data.
- stall_if  out  1  hold PC and IF/ID.
- stall_pipe  out  1  freeze whole pipeline.

Function
REQ-003 States SHALL be OCIOSO, BUSY_I, BUSY_D; exactly one access outstanding at a time.
REQ-004 Arbitration (in OCIOSO, or in the completion cycle of BUSY_I/BUSY_D): data request wins over fetch, unless fair_cnt equals FAIR_MAX and if_req is high, in which case fetch wins.
REQ-005 fair_cnt SHALL increment on each data grant made while if_req is high, saturate at FAIR_MAX, and clear on every fetch grant.
REQ-006 On grant, mem_addr, mem_wdata and the request type SHALL be latched. Latched values SHALL drive the memory outputs for the whole access. Later changes on the requester inputs SHALL be ignored until completion.
REQ-007 mem_ler SHALL be high during every cycle of a fetch or load. mem_esc SHALL be high only during the first cycle of a store. Both strobes SHALL be 0 in OCIOSO.
REQ-008 A latency counter SHALL load MEM_LAT at grant and decrement each cycle. The completion cycle is the cycle in which the counter reaches 0.
REQ-009 Completion SHALL register mem_rdata into if_rdata or dm_rdata (loads only) and pulse the matching valid for one cycle. Stores SHALL leave dm_rdata unchanged.
REQ-010 If any request is pending at completion, the next grant SHALL be made in the same cycle with no bubble; otherwise the FSM SHALL go to OCIOSO.
REQ-011 If dm_read and dm_write are both high at grant, the access SHALL be performed as a store and dm_err SHALL pulse in the grant cycle.
REQ-012 stall_if SHALL equal if_req & ~if_valid. stall_pipe SHALL equal (dm_read|dm_write) & ~dm_valid. Both are combinational.
REQ-013 if_rdata and dm_rdata SHALL hold their last value between accesses.

Reset
REQ-014 While reset_n is low: state=OCIOSO; counters=0; all outputs 0, including data buses and strobes.
REQ-015 Reset mid-access SHALL abort the access with no valid pulse. The first grant SHALL occur no earlier than the first clock edge after reset_n deasserts.

Structure
REQ-016 A shared package SHALL hold the state enum (OCIOSO, BUSY_I, BUSY_D), the 32-bit word width and the MEM_LAT/FAIR_MAX legal bounds.
REQ-017 The fairness counter plus grant decision SHALL be one sub-module, arbitro_prioridade. The FSM, latency counter and datapath registers SHALL stay in the top module.

Verification
REQ-018 The bench SHALL model the shared memory with MEM_LAT latency and cover:
- Fetch alone, MEM_LAT=1, if_addr=0x40, memory word 0x8C010004 -> if_valid at cycle 2 after request, if_rdata=0x8C010004, stall_if high for exactly 1 cycle.
- Load and fetch raised in the same cycle, dm_addr=0x100 -> data granted first. dm_valid, then if_valid on the next completion, with no idle cycle between.
- Continuous data requests with if_req held, FAIR_MAX=4 -> 4 data grants, 1 fetch grant, fair_cnt back to 0.
- Store 0xDEADBEEF to 0x200, then load 0x200 -> mem_esc high for 1 cycle; dm_rdata=0xDEADBEEF.
- dm_read=dm_write=1 -> store performed, dm_err pulse of 1 cycle.
- reset_n low during BUSY_D with MEM_LAT=3 -> no dm_valid; outputs 0; first grant on the first edge after release.
